pipeline_ctrl: RTL and testbench

Consumer side of the main control decoder in the 5-stage MIPS pipeline. Takes the decoded control word and register fields of the instruction in ID. Carries the control word through the ID/EX, EX/MEM and MEM/WB registers and resolves the hazards that come with it: load-use stall, branch/jump flush, and EX-stage forwarding selects. Datapath registers outside this block follow the same stall/flush strobes it emits.

---
 rtl/pipeline_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Control-word pipeline (ID/EX, EX/MEM, MEM/WB) with load-use stall,
// branch/jump flush and EX-stage forwarding selects.
//
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   id_*               decoder outputs and register fields of the ID instruction
//   ex_Zero            ALU zero flag of the EX instruction
//   ex_*, mem_*, wb_*  registered control word per stage
//   pc_write           PC load enable
//   ifid_write         IF/ID load enable
//   ifid_flush         IF/ID clears to NOP on the next edge
//   pc_src             00 PC+4, 01 branch target, 10 jump target
//   fwd_a, fwd_b       ALU operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
module pipeline_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic       id_RegDst,
  input  logic       id_Jump,
  input  logic       id_Branch,
  input  logic       id_MemRead,
  input  logic       id_MemtoReg,
  input  logic       id_MemWrite,
  input  logic       id_ALUSrc,
  input  logic       id_RegWrite,
  input  logic [1:0] id_ALUOp,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] id_rd,
  input  logic       ex_Zero,
  output logic       ex_ALUSrc,
  output logic [1:0] ex_ALUOp,
  output logic       ex_Branch,
  output logic [4:0] ex_rs,
  output logic [4:0] ex_rt,
  output logic [4:0] ex_dst,
  output logic       mem_MemRead,
  output logic       mem_MemWrite,
  output logic       mem_RegWrite,
  output logic       mem_MemtoReg,
  output logic [4:0] mem_dst,
  output logic       wb_RegWrite,
  output logic       wb_MemtoReg,
  output logic [4:0] wb_dst,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic [1:0] pc_src,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic [1:0] alu_op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
  } id_ex_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic [4:0] dst;
  } ex_mem_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] dst;
  } mem_wb_t;

  id_ex_t  ex_q, ex_d;
  ex_mem_t mem_q, mem_d;
  mem_wb_t wb_q, wb_d;

  logic bt, lu, jt;
  logic rt_used;

  // rt is a source only for R-type, stores and branches
  assign rt_used = id_RegDst | id_MemWrite | id_Branch;

  // hazards are masked during reset so the front end free-runs
  always_comb begin
    bt = !RST && ex_q.branch && ex_Zero;
    lu = !RST && ex_q.mem_read && (ex_q.dst != 5'd0) && !id_Jump
         && ((ex_q.dst == id_rs)
             || ((ex_q.dst == id_rt) && rt_used));
    jt = !RST && id_Jump && !bt;
  end

  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    pc_src     = 2'b00;
    priority case (1'b1)
      bt: begin
        pc_src     = 2'b01;
        ifid_flush = 1'b1;
      end
      lu: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
      end
      jt: begin
        pc_src     = 2'b10;
        ifid_flush = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ex_d.reg_write  = id_RegWrite;
    ex_d.mem_to_reg = id_MemtoReg;
    ex_d.mem_read   = id_MemRead;
    ex_d.mem_write  = id_MemWrite;
    ex_d.branch     = id_Branch;
    ex_d.alu_src    = id_ALUSrc;
    ex_d.alu_op     = id_ALUOp;
    ex_d.rs         = id_rs;
    ex_d.rt         = id_rt;
    ex_d.dst        = id_RegDst ? id_rd : id_rt;
    // a jump carries its own word but must not write anything
    if (jt) begin
      ex_d.reg_write = 1'b0;
      ex_d.mem_read  = 1'b0;
      ex_d.mem_write = 1'b0;
    end
    if (bt || lu) ex_d = '0;
  end

  always_comb begin
    mem_d.reg_write  = ex_q.reg_write;
    mem_d.mem_to_reg = ex_q.mem_to_reg;
    mem_d.mem_read   = ex_q.mem_read;
    mem_d.mem_write  = ex_q.mem_write;
    mem_d.dst        = ex_q.dst;
    wb_d.reg_write   = mem_q.reg_write;
    wb_d.mem_to_reg  = mem_q.mem_to_reg;
    wb_d.dst         = mem_q.dst;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (mem_q.reg_write && mem_q.dst != 5'd0 && mem_q.dst == src)
      return 2'b10;
    else if (wb_q.reg_write && wb_q.dst != 5'd0 && wb_q.dst == src)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!RST) begin
      fwd_a = fwd_sel(ex_q.rs);
      fwd_b = fwd_sel(ex_q.rt);
    end
  end

  assign ex_ALUSrc    = ex_q.alu_src;
  assign ex_ALUOp     = ex_q.alu_op;
  assign ex_Branch    = ex_q.branch;
  assign ex_rs        = ex_q.rs;
  assign ex_rt        = ex_q.rt;
  assign ex_dst       = ex_q.dst;
  assign mem_MemRead  = mem_q.mem_read;
  assign mem_MemWrite = mem_q.mem_write;
  assign mem_RegWrite = mem_q.reg_write;
  assign mem_MemtoReg = mem_q.mem_to_reg;
  assign mem_dst      = mem_q.dst;
  assign wb_RegWrite  = wb_q.reg_write;
  assign wb_MemtoReg  = wb_q.mem_to_reg;
  assign wb_dst       = wb_q.dst;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: reset, latency, load-use,
// branch/jump flush, forwarding priority and mid-pipeline reset.
module tb_pipeline_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       id_RegDst, id_Jump, id_Branch, id_MemRead;
  logic       id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite;
  logic [1:0] id_ALUOp;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       ex_Zero;
  logic       ex_ALUSrc, ex_Branch;
  logic [1:0] ex_ALUOp;
  logic [4:0] ex_rs, ex_rt, ex_dst;
  logic       mem_MemRead, mem_MemWrite, mem_RegWrite, mem_MemtoReg;
  logic [4:0] mem_dst;
  logic       wb_RegWrite, wb_MemtoReg;
  logic [4:0] wb_dst;
  logic       pc_write, ifid_write, ifid_flush;
  logic [1:0] pc_src, fwd_a, fwd_b;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  pipeline_ctrl dut (
    .CLK(CLK), .RST(RST),
    .id_RegDst(id_RegDst), .id_Jump(id_Jump), .id_Branch(id_Branch),
    .id_MemRead(id_MemRead), .id_MemtoReg(id_MemtoReg),
    .id_MemWrite(id_MemWrite), .id_ALUSrc(id_ALUSrc),
    .id_RegWrite(id_RegWrite), .id_ALUOp(id_ALUOp),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_Zero(ex_Zero),
    .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp), .ex_Branch(ex_Branch),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_RegWrite(mem_RegWrite), .mem_MemtoReg(mem_MemtoReg),
    .mem_dst(mem_dst), .wb_RegWrite(wb_RegWrite),
    .wb_MemtoReg(wb_MemtoReg), .wb_dst(wb_dst),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .pc_src(pc_src),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_id;
    id_RegDst = 0; id_Jump = 0; id_Branch = 0; id_MemRead = 0;
    id_MemtoReg = 0; id_MemWrite = 0; id_ALUSrc = 0; id_RegWrite = 0;
    id_ALUOp = 2'b00; id_rs = 0; id_rt = 0; id_rd = 0; ex_Zero = 0;
  endtask

  task automatic drain;
    clear_id();
    repeat (3) tick();
  endtask

  task automatic set_rtype(input logic [4:0] rs, rt, rd);
    clear_id();
    id_RegDst = 1; id_RegWrite = 1; id_ALUOp = 2'b10;
    id_rs = rs; id_rt = rt; id_rd = rd;
  endtask

  task automatic set_lw(input logic [4:0] rs, rt);
    clear_id();
    id_MemRead = 1; id_MemtoReg = 1; id_ALUSrc = 1; id_RegWrite = 1;
    id_rs = rs; id_rt = rt;
  endtask

  task automatic test_reset;
    RST = 1;
    set_rtype(5'd1, 5'd2, 5'd3);
    #1;
    tests++; if (pc_write !== 1'b1) begin fails++;
      $display("FAIL rst_pc_write got %0d exp 1", pc_write); end
    tests++; if (ifid_flush !== 1'b0 || ifid_write !== 1'b1) begin fails++;
      $display("FAIL rst_ifid got flush=%0d wr=%0d exp 0/1", ifid_flush, ifid_write); end
    tests++; if (pc_src !== 2'b00 || fwd_a !== 2'b00 || fwd_b !== 2'b00) begin fails++;
      $display("FAIL rst_sel got pc_src=%0d fa=%0d fb=%0d exp 0", pc_src, fwd_a, fwd_b); end
    tick(); tick(); tick();
    tests++; if ({ex_ALUOp, ex_dst, ex_rs, ex_rt, ex_ALUSrc, ex_Branch} !== '0) begin fails++;
      $display("FAIL rst_ex got op=%0d dst=%0d rs=%0d exp 0", ex_ALUOp, ex_dst, ex_rs); end
    tests++; if ({mem_RegWrite, mem_MemRead, mem_MemWrite, mem_MemtoReg, mem_dst,
                  wb_RegWrite, wb_MemtoReg, wb_dst} !== '0) begin fails++;
      $display("FAIL rst_memwb got mem_rw=%0d wb_rw=%0d exp 0", mem_RegWrite, wb_RegWrite); end
    RST = 0;
    drain();
  endtask

  task automatic test_rtype;
    set_rtype(5'd1, 5'd7, 5'd5);
    tick();
    clear_id();
    tests++; if (ex_ALUOp !== 2'b10 || ex_dst !== 5'd5) begin fails++;
      $display("FAIL rtype_ex got op=%0d dst=%0d exp 2/5", ex_ALUOp, ex_dst); end
    tick();
    tests++; if (mem_RegWrite !== 1'b1 || mem_dst !== 5'd5) begin fails++;
      $display("FAIL rtype_mem got rw=%0d dst=%0d exp 1/5", mem_RegWrite, mem_dst); end
    tests++; if (ex_ALUOp !== 2'b00 || ex_dst !== 5'd0) begin fails++;
      $display("FAIL rtype_ex_next got op=%0d dst=%0d exp 0/0", ex_ALUOp, ex_dst); end
    tick();
    tests++; if (wb_RegWrite !== 1'b1 || wb_dst !== 5'd5) begin fails++;
      $display("FAIL rtype_wb got rw=%0d dst=%0d exp 1/5", wb_RegWrite, wb_dst); end
    drain();
  endtask

  task automatic test_load_use;
    set_lw(5'd2, 5'd8);
    tick();
    set_rtype(5'd8, 5'd9, 5'd10);
    #1;
    tests++; if (pc_write !== 1'b0 || ifid_write !== 1'b0) begin fails++;
      $display("FAIL lu_stall got pcw=%0d ifw=%0d exp 0/0", pc_write, ifid_write); end
    tests++; if (ifid_flush !== 1'b0 || pc_src !== 2'b00) begin fails++;
      $display("FAIL lu_flush got flush=%0d pc_src=%0d exp 0/0", ifid_flush, pc_src); end
    tick();
    tests++; if (ex_dst !== 5'd0 || ex_rs !== 5'd0 || ex_ALUOp !== 2'b00) begin fails++;
      $display("FAIL lu_bubble got dst=%0d rs=%0d op=%0d exp 0", ex_dst, ex_rs, ex_ALUOp); end
    tests++; if (mem_MemRead !== 1'b1 || mem_dst !== 5'd8) begin fails++;
      $display("FAIL lu_lw_mem got mr=%0d dst=%0d exp 1/8", mem_MemRead, mem_dst); end
    tests++; if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin fails++;
      $display("FAIL lu_release got pcw=%0d ifw=%0d exp 1/1", pc_write, ifid_write); end
    tick();
    clear_id();
    tests++; if (ex_rs !== 5'd8 || ex_dst !== 5'd10) begin fails++;
      $display("FAIL lu_add_ex got rs=%0d dst=%0d exp 8/10", ex_rs, ex_dst); end
    tests++; if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin fails++;
      $display("FAIL lu_fwd got fa=%0d fb=%0d exp 1/0", fwd_a, fwd_b); end
    drain();
    // rt is only a destination for an I-type ALU op: no stall
    set_lw(5'd2, 5'd8);
    tick();
    clear_id();
    id_ALUSrc = 1; id_RegWrite = 1; id_rs = 5'd1; id_rt = 5'd8;
    #1;
    tests++; if (pc_write !== 1'b1) begin fails++;
      $display("FAIL lu_itype_rt got pcw=%0d exp 1", pc_write); end
    // a store reads rt, so it does stall
    id_RegWrite = 0; id_MemWrite = 1;
    #1;
    tests++; if (pc_write !== 1'b0) begin fails++;
      $display("FAIL lu_sw_rt got pcw=%0d exp 0", pc_write); end
    drain();
    // load into $0 never stalls
    set_lw(5'd2, 5'd0);
    tick();
    set_rtype(5'd0, 5'd0, 5'd4);
    #1;
    tests++; if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin fails++;
      $display("FAIL lu_r0 got pcw=%0d ifw=%0d exp 1/1", pc_write, ifid_write); end
    drain();
  endtask

  task automatic test_branch;
    clear_id();
    id_Branch = 1; id_ALUOp = 2'b01; id_rs = 5'd1; id_rt = 5'd2;
    tick();
    set_rtype(5'd3, 5'd4, 5'd5);
    ex_Zero = 1;
    #1;
    tests++; if (pc_src !== 2'b01 || ifid_flush !== 1'b1) begin fails++;
      $display("FAIL bt_sel got pc_src=%0d flush=%0d exp 1/1", pc_src, ifid_flush); end
    tests++; if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin fails++;
      $display("FAIL bt_wr got pcw=%0d ifw=%0d exp 1/1", pc_write, ifid_write); end
    tick();
    tests++; if ({ex_ALUOp, ex_dst, ex_rs, ex_rt, ex_Branch, ex_ALUSrc} !== '0) begin fails++;
      $display("FAIL bt_bubble got op=%0d dst=%0d rs=%0d exp 0", ex_ALUOp, ex_dst, ex_rs); end
    drain();
    clear_id();
    id_Branch = 1; id_ALUOp = 2'b01; id_rs = 5'd1; id_rt = 5'd2;
    tick();
    set_rtype(5'd3, 5'd4, 5'd5);
    ex_Zero = 0;
    #1;
    tests++; if (pc_src !== 2'b00 || ifid_flush !== 1'b0) begin fails++;
      $display("FAIL bnt_sel got pc_src=%0d flush=%0d exp 0/0", pc_src, ifid_flush); end
    tick();
    tests++; if (ex_dst !== 5'd5 || ex_ALUOp !== 2'b10) begin fails++;
      $display("FAIL bnt_ex got dst=%0d op=%0d exp 5/2", ex_dst, ex_ALUOp); end
    drain();
  endtask

  task automatic test_forward;
    set_rtype(5'd0, 5'd0, 5'd3); tick();
    set_rtype(5'd0, 5'd0, 5'd3); tick();
    set_rtype(5'd3, 5'd3, 5'd4); tick();
    clear_id();
    tests++; if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin fails++;
      $display("FAIL fwd_both got fa=%0d fb=%0d exp 2/2", fwd_a, fwd_b); end
    set_rtype(5'd0, 5'd0, 5'd3); tick();
    set_rtype(5'd0, 5'd0, 5'd0); tick();
    set_rtype(5'd3, 5'd6, 5'd4); tick();
    clear_id();
    tests++; if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin fails++;
      $display("FAIL fwd_wb got fa=%0d fb=%0d exp 1/0", fwd_a, fwd_b); end
    set_rtype(5'd0, 5'd0, 5'd0); tick();
    set_rtype(5'd0, 5'd0, 5'd0); tick();
    set_rtype(5'd0, 5'd0, 5'd4); tick();
    clear_id();
    tests++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin fails++;
      $display("FAIL fwd_r0 got fa=%0d fb=%0d exp 0/0", fwd_a, fwd_b); end
    drain();
  endtask

  task automatic test_jump;
    set_lw(5'd2, 5'd6);
    tick();
    clear_id();
    id_Jump = 1; id_rs = 5'd6;
    #1;
    tests++; if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin fails++;
      $display("FAIL jt_nostall got pcw=%0d ifw=%0d exp 1/1", pc_write, ifid_write); end
    tests++; if (pc_src !== 2'b10 || ifid_flush !== 1'b1) begin fails++;
      $display("FAIL jt_sel got pc_src=%0d flush=%0d exp 2/1", pc_src, ifid_flush); end
    tick();
    clear_id();
    tests++; if (mem_MemRead !== 1'b1 || mem_dst !== 5'd6) begin fails++;
      $display("FAIL jt_lw_mem got mr=%0d dst=%0d exp 1/6", mem_MemRead, mem_dst); end
    tests++; if (ex_rs !== 5'd6 || ex_dst !== 5'd0) begin fails++;
      $display("FAIL jt_ex got rs=%0d dst=%0d exp 6/0", ex_rs, ex_dst); end
    drain();
  endtask

  task automatic test_reset_mid;
    set_rtype(5'd0, 5'd0, 5'd1); tick();
    set_rtype(5'd0, 5'd0, 5'd2); tick();
    set_rtype(5'd0, 5'd0, 5'd3); tick();
    tests++; if (wb_RegWrite !== 1'b1 || mem_dst !== 5'd2) begin fails++;
      $display("FAIL rmid_fill got wb_rw=%0d mem_dst=%0d exp 1/2", wb_RegWrite, mem_dst); end
    // hold a load-use pattern so reset lands mid-stall
    set_lw(5'd1, 5'd8); tick();
    set_rtype(5'd8, 5'd0, 5'd9);
    RST = 1;
    #1;
    tests++; if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin fails++;
      $display("FAIL rmid_nostall got pcw=%0d ifw=%0d exp 1/1", pc_write, ifid_write); end
    tick();
    tests++; if ({ex_dst, ex_rs, ex_rt, ex_ALUOp, mem_RegWrite, mem_MemRead, mem_dst,
                  wb_RegWrite, wb_MemtoReg, wb_dst} !== '0) begin fails++;
      $display("FAIL rmid_clear got ex_dst=%0d mem_rw=%0d wb_rw=%0d exp 0",
               ex_dst, mem_RegWrite, wb_RegWrite); end
    tests++; if (pc_write !== 1'b1 || pc_src !== 2'b00) begin fails++;
      $display("FAIL rmid_pc got pcw=%0d pc_src=%0d exp 1/0", pc_write, pc_src); end
    RST = 0;
    clear_id();
    tick();
    tests++; if (ex_dst !== 5'd0 || mem_RegWrite !== 1'b0) begin fails++;
      $display("FAIL rmid_noreplay got ex_dst=%0d mem_rw=%0d exp 0/0", ex_dst, mem_RegWrite); end
  endtask

  initial begin
    clear_id();
    RST = 1;
    test_reset();
    test_rtype();
    test_load_use();
    test_branch();
    test_forward();
    test_jump();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
